// File: rtl/iob_sync_fifo_asym.sv
// Single-clock FIFO with a wide write port and a narrow read port.
// Each written word is read back as R slices, least-significant slice first.
module iob_sync_fifo_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4,
  localparam int RATIO_W = $clog2(W_DATA_W / R_DATA_W),
  localparam int LEVEL_W = ADDR_W + RATIO_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  output logic                w_ovf,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic                r_udf,
  output logic [LEVEL_W-1:0]  level
);

  localparam int R     = 2 ** RATIO_W;
  localparam int PTR_W = ADDR_W + RATIO_W;
  localparam int CAP   = 2 ** PTR_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int OFF_W = $clog2(W_DATA_W);
  localparam logic [PTR_W-1:0] SLICE_MASK = PTR_W'(R - 1);

  logic [W_DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_w_ptr;
  logic [PTR_W-1:0]    r_r_ptr;
  logic [LEVEL_W-1:0]  r_level;
  logic [R_DATA_W-1:0] r_rdata;
  logic                r_w_ovf;
  logic                r_r_udf;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [PTR_W-1:0]    w_slice;
  logic [OFF_W-1:0]    w_bit_off;
  logic [LEVEL_W-1:0]  w_level_nxt;

  // Flags depend only on the registered level, so a same-cycle read never
  // frees room for a write and a same-cycle write never feeds a read.
  assign w_full  = (r_level > LEVEL_W'(CAP - R));
  assign r_empty = (r_level == '0);

  assign w_wr_acc = w_en & ~w_full;
  assign w_rd_acc = r_en & ~r_empty;

  // Upper read-pointer bits select the word, lower bits select the slice.
  assign w_rd_addr = r_r_ptr[PTR_W-1 -: ADDR_W];
  assign w_slice   = r_r_ptr & SLICE_MASK;
  assign w_bit_off = OFF_W'(32'(w_slice) * 32'(R_DATA_W));

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc) w_level_nxt = w_level_nxt + LEVEL_W'(R);
    if (w_rd_acc) w_level_nxt = w_level_nxt - LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr && w_wr_acc) r_mem[r_w_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_level <= '0;
      r_rdata <= '0;
      r_w_ovf <= 1'b0;
      r_r_udf <= 1'b0;
    end else if (clr) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_level <= '0;
      r_rdata <= '0;
      r_w_ovf <= 1'b0;
      r_r_udf <= 1'b0;
    end else begin
      r_w_ovf <= w_en & w_full;
      r_r_udf <= r_en & r_empty;
      r_level <= w_level_nxt;
      if (w_wr_acc) r_w_ptr <= r_w_ptr + ADDR_W'(1);
      if (w_rd_acc) begin
        r_r_ptr <= r_r_ptr + PTR_W'(1);
        r_rdata <= r_mem[w_rd_addr][w_bit_off +: R_DATA_W];
      end
    end
  end

  assign w_ovf  = r_w_ovf;
  assign r_udf  = r_r_udf;
  assign r_data = r_rdata;
  assign level  = r_level;

endmodule

// File: tb/tb_iob_sync_fifo_asym.sv
// Bench for iob_sync_fifo_asym (32-bit writes, 8-bit reads, 4 words deep)
// against a byte-queue reference model.
module tb_iob_sync_fifo_asym;

  localparam int W = 32;
  localparam int RW = 8;
  localparam int AW = 2;
  localparam int R = W / RW;
  localparam int CAP = (2 ** AW) * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          w_en = 1'b0;
  logic [W-1:0]  w_data = '0;
  logic          w_full;
  logic          w_ovf;
  logic          r_en = 1'b0;
  logic [RW-1:0] r_data;
  logic          r_empty;
  logic          r_udf;
  logic [4:0]    level;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a queue of read slices.
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] m_rdata = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  iob_sync_fifo_asym #(.W_DATA_W(W), .R_DATA_W(RW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .w_en(w_en), .w_data(w_data), .w_full(w_full), .w_ovf(w_ovf),
    .r_en(r_en), .r_data(r_data), .r_empty(r_empty), .r_udf(r_udf),
    .level(level)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    exp_q.delete();
    m_rdata = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  // Apply one cycle of stimulus, then advance the model by the same edge.
  task automatic drive(input logic we, input logic [W-1:0] wd, input logic re, input logic cl);
    bit full_m, empty_m;
    full_m = exp_q.size() > CAP - R;
    empty_m = exp_q.size() == 0;
    w_en = we; w_data = wd; r_en = re; clr = cl;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    if (cl) begin
      model_reset();
    end else begin
      m_ovf = we && full_m;
      m_udf = re && empty_m;
      if (re && !empty_m) m_rdata = exp_q.pop_front();
      if (we && !full_m) for (int k = 0; k < R; k++) exp_q.push_back(wd[k*RW +: RW]);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (r_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", r_empty); end
    checks++; if (w_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", w_full); end
    checks++; if (r_data !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", r_data); end
    checks++; if (w_ovf !== 1'b0 || r_udf !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", w_ovf, r_udf); end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_idle_level got=%0d exp=0", level); end
  endtask

  task automatic test_basic_order();
    logic [RW-1:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    drive(1'b1, 32'h44332211, 1'b0, 1'b0);
    checks++; if (level !== 5'd4) begin failures++; $display("FAIL basic_level got=%0d exp=4", level); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (r_data !== exp_b[i]) begin failures++; $display("FAIL basic_slice%0d got=%h exp=%h", i, r_data, exp_b[i]); end
    end
    checks++; if (r_empty !== 1'b1 || level !== 5'd0) begin failures++; $display("FAIL basic_empty got=%b/%0d exp=1/0", r_empty, level); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (level !== 5'd16 || w_full !== 1'b1) begin failures++; $display("FAIL full_level got=%0d/%b exp=16/1", level, w_full); end
    drive(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (w_ovf !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL ovf_pulse got=%b/%0d exp=1/16", w_ovf, level); end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (w_ovf !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", w_ovf); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (r_data !== m_rdata) begin failures++; $display("FAIL full_read%0d got=%h exp=%h", i, r_data, m_rdata); end
    end
    checks++; if (level !== 5'd13 || w_full !== 1'b1) begin failures++; $display("FAIL full_at13 got=%0d/%b exp=13/1", level, w_full); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (level !== 5'd12 || w_full !== 1'b0) begin failures++; $display("FAIL full_at12 got=%0d/%b exp=12/0", level, w_full); end
    while (exp_q.size() > 0) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (r_data !== m_rdata) begin failures++; $display("FAIL full_drain got=%h exp=%h", r_data, m_rdata); end
    end
  endtask

  task automatic test_underflow();
    logic [RW-1:0] held;
    held = m_rdata;
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (r_udf !== 1'b1) begin failures++; $display("FAIL udf_pulse got=%b exp=1", r_udf); end
    checks++; if (r_data !== held || level !== 5'd0) begin failures++; $display("FAIL udf_hold got=%h/%0d exp=%h/0", r_data, level, held); end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (r_udf !== 1'b0) begin failures++; $display("FAIL udf_one_cycle got=%b exp=0", r_udf); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b0);
    checks++; if (level !== 5'd7 || w_ovf !== 1'b0 || r_data !== m_rdata) begin failures++; $display("FAIL sim_mid got=%0d/%b/%h exp=7/0/%h", level, w_ovf, r_data, m_rdata); end
    while (exp_q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b0);
    checks++; if (level !== 5'd15 || w_ovf !== 1'b1 || r_data !== m_rdata) begin failures++; $display("FAIL sim_full got=%0d/%b/%h exp=15/1/%h", level, w_ovf, r_data, m_rdata); end
    while (exp_q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b0);
    checks++; if (level !== 5'd4 || r_udf !== 1'b1) begin failures++; $display("FAIL sim_empty got=%0d/%b exp=4/1", level, r_udf); end
    while (exp_q.size() > 0) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (r_data !== m_rdata) begin failures++; $display("FAIL sim_drain got=%h exp=%h", r_data, m_rdata); end
    end
  endtask

  task automatic test_wrap();
    int written, cyc;
    logic we, re;
    written = 0; cyc = 0;
    while ((written < 20 || exp_q.size() > 0) && cyc < 600) begin
      we = (written < 20) && ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 2) != 0);
      if (we && exp_q.size() <= CAP - R) written++;
      drive(we, $urandom, re, 1'b0);
      cyc++;
      checks++;
      if (r_data !== m_rdata || level !== 5'(exp_q.size()) || w_ovf !== m_ovf || r_udf !== m_udf) begin
        failures++;
        $display("FAIL wrap_cyc%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", cyc, r_data, level, w_ovf, r_udf,
                 m_rdata, exp_q.size(), m_ovf, m_udf);
      end
    end
    checks++; if (cyc >= 600) begin failures++; $display("FAIL wrap_timeout got=%0d words exp=20", written); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (level !== 5'd9) begin failures++; $display("FAIL clr_setup got=%0d exp=9", level); end
    drive(1'b1, $urandom, 1'b1, 1'b1);
    checks++; if (level !== 5'd0 || r_empty !== 1'b1 || r_data !== 8'h00) begin failures++; $display("FAIL clr_state got=%0d/%b/%h exp=0/1/00", level, r_empty, r_data); end
    checks++; if (w_ovf !== 1'b0 || r_udf !== 1'b0) begin failures++; $display("FAIL clr_pulses got=%b%b exp=00", w_ovf, r_udf); end
    drive(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (r_data !== 8'hD4) begin failures++; $display("FAIL clr_resume got=%h exp=d4", r_data); end
    while (exp_q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level !== 5'd0 || r_empty !== 1'b1 || w_full !== 1'b0 || r_data !== 8'h00) begin
      failures++; $display("FAIL async_rst got=%0d/%b/%b/%h exp=0/1/0/00", level, r_empty, w_full, r_data);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (r_data !== 8'h0D || level !== 5'd3) begin failures++; $display("FAIL async_resume got=%h/%0d exp=0d/3", r_data, level); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_full_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
